coin_classifier: RTL and testbench



---
 rtl/coin_classifier_pkg.sv | 28 ++
 rtl/coin_classifier_if.sv | 28 ++
 rtl/coin_classifier_credit.sv | 39 +++
 rtl/coin_classifier.sv | 173 +++++++++++++++++
 tb/tb_coin_classifier.sv | 126 ++++++++++++
 5 files changed

// File: rtl/coin_classifier_pkg.sv
// coin_pkg: shared types and defaults for the coin classifier.
// Holds the FSM state encoding, the default four-coin window/value tables
// and the window-match helper used by the classifier.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    OVERSIZE = 2'd2
  } state_e;

  localparam int DEF_NUM_TYPES = 4;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_CREDIT_W  = 12;

  // Index 0 is the rightmost entry.
  localparam logic [3:0][7:0]  DEF_WIN_MIN  = {8'd14, 8'd10, 8'd6, 8'd2};
  localparam logic [3:0][7:0]  DEF_WIN_MAX  = {8'd16, 8'd12, 8'd8, 8'd4};
  localparam logic [3:0][11:0] DEF_COIN_VAL = {12'd100, 12'd25, 12'd5, 12'd10};

  // True when cnt lies inside the inclusive window [lo, hi].
  function automatic logic win_match(input logic [31:0] cnt,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/coin_classifier_if.sv
// coin_classifier_if: sensor/credit bus between the coin sensor front end,
// the classifier and the vending control FSM. The classifier uses the
// slave modport; the side driving the sensor uses master.
interface coin_classifier_if #(
  parameter int NUM_TYPES = 4,
  parameter int CREDIT_W  = 12
);
  localparam int TYPE_W = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1;

  logic                 coinSensor;
  logic                 creditClear;
  logic                 coinValid;
  logic                 coinReject;
  logic [NUM_TYPES-1:0] coinDetected;
  logic [TYPE_W-1:0]    coinType;
  logic [CREDIT_W-1:0]  credit;
  logic                 busy;

  modport master (
    output coinSensor, creditClear,
    input  coinValid, coinReject, coinDetected, coinType, credit, busy
  );

  modport slave (
    input  coinSensor, creditClear,
    output coinValid, coinReject, coinDetected, coinType, credit, busy
  );
endinterface

// File: rtl/coin_classifier_credit.sv
// coin_credit_acc: saturating credit accumulator. A clear and an add in the
// same cycle give clear-then-add, so the total becomes exactly add_val.
module coin_credit_acc
  import coin_pkg::*;
#(
  parameter int CREDIT_W = DEF_CREDIT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                add_en,
  input  logic [CREDIT_W-1:0] add_val,
  output logic [CREDIT_W-1:0] credit
);
  logic [CREDIT_W-1:0] credit_r;
  logic [CREDIT_W-1:0] base_s;
  logic [CREDIT_W-1:0] add_s;
  logic [CREDIT_W:0]   sum_s;
  logic [CREDIT_W-1:0] credit_n;

  // Next total: optional clear, optional add, clamp at all-ones on carry.
  always_comb begin
    base_s   = clear ? '0 : credit_r;
    add_s    = add_en ? add_val : '0;
    sum_s    = {1'b0, base_s} + {1'b0, add_s};
    credit_n = sum_s[CREDIT_W] ? {CREDIT_W{1'b1}} : sum_s[CREDIT_W-1:0];
  end

  // Credit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_r <= '0;
    end else begin
      credit_r <= credit_n;
    end
  end

  assign credit = credit_r;
endmodule

// File: rtl/coin_classifier.sv
// coin_classifier: measures the coin-sensor high-pulse width in clocks and
// classifies it against NUM_TYPES inclusive windows (lowest index wins).
// Optional macro COIN_CLASSIFIER_DEBOUNCE_EN adds a two-sample glitch
// filter in front of the FSM (+2 cycles of latency to every output).
module coin_classifier
  import coin_pkg::*;
#(
  parameter int NUM_TYPES = DEF_NUM_TYPES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int CREDIT_W  = DEF_CREDIT_W,
  parameter logic [NUM_TYPES-1:0][CNT_W-1:0]    WIN_MIN  = DEF_WIN_MIN,
  parameter logic [NUM_TYPES-1:0][CNT_W-1:0]    WIN_MAX  = DEF_WIN_MAX,
  parameter logic [NUM_TYPES-1:0][CREDIT_W-1:0] COIN_VAL = DEF_COIN_VAL
) (
  input  logic             clk,
  input  logic             reset,
  coin_classifier_if.slave bus
);
  localparam int TYPE_W = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                 sensor_s;
  logic                 arm_r;
  state_e               state_r, state_n;
  logic [CNT_W-1:0]     cnt_r, cnt_n;
  logic                 hit_s, match_s;
  logic [TYPE_W-1:0]    idx_s;
  logic                 accept_s, reject_s;
  logic                 valid_r, reject_r, busy_r;
  logic [NUM_TYPES-1:0] det_r;
  logic [TYPE_W-1:0]    type_r;
  logic [CREDIT_W-1:0]  credit_s;

`ifdef COIN_CLASSIFIER_DEBOUNCE_EN
  logic samp_r, filt_r;

  // Glitch filter: follow the sensor only after two equal samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_r <= 1'b0;
      filt_r <= 1'b0;
    end else begin
      samp_r <= bus.coinSensor;
      if (bus.coinSensor == samp_r) begin
        filt_r <= samp_r;
      end
    end
  end

  assign sensor_s = filt_r;
`else
  assign sensor_s = bus.coinSensor;
`endif

  // Arm flag: a measurement may only start after a low sample, so a
  // sensor already high at reset release is never measured.
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_r <= 1'b0;
    end else begin
      arm_r <= ~sensor_s;
    end
  end

  // Window match on the current count, lowest matching index wins.
  always_comb begin
    hit_s   = 1'b0;
    idx_s   = '0;
    match_s = 1'b0;
    for (int i = NUM_TYPES - 1; i >= 0; i--) begin
      match_s = win_match(32'(cnt_r), 32'(WIN_MIN[i]), 32'(WIN_MAX[i]));
      hit_s   = hit_s | match_s;
      idx_s   = match_s ? TYPE_W'(i) : idx_s;
    end
  end

  // FSM next state, counter update and classify/reject decisions.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    accept_s = 1'b0;
    reject_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sensor_s && arm_r) begin
          state_n = MEASURE;
          cnt_n   = CNT_ONE;
        end else begin
          state_n = IDLE;
        end
      end
      MEASURE: begin
        if (sensor_s) begin
          if (cnt_r == CNT_MAX - CNT_ONE) begin
            cnt_n   = CNT_MAX;
            state_n = OVERSIZE;
          end else begin
            cnt_n = cnt_r + CNT_ONE;
          end
        end else begin
          state_n  = IDLE;
          cnt_n    = '0;
          accept_s = hit_s;
          reject_s = ~hit_s;
        end
      end
      OVERSIZE: begin
        if (sensor_s) begin
          state_n = OVERSIZE;
        end else begin
          state_n  = IDLE;
          cnt_n    = '0;
          reject_s = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // FSM state and pulse-width counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Registered outputs: one-cycle valid/reject pulses, held type/one-hot.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r  <= 1'b0;
      reject_r <= 1'b0;
      busy_r   <= 1'b0;
      det_r    <= '0;
      type_r   <= '0;
    end else begin
      valid_r  <= accept_s;
      reject_r <= reject_s;
      busy_r   <= (state_n != IDLE);
      if (accept_s) begin
        det_r  <= NUM_TYPES'(1) << idx_s;
        type_r <= idx_s;
      end else if (reject_s) begin
        det_r  <= '0;
      end
    end
  end

  coin_credit_acc #(
    .CREDIT_W(CREDIT_W)
  ) u_credit (
    .clk    (clk),
    .reset  (reset),
    .clear  (bus.creditClear),
    .add_en (accept_s),
    .add_val(COIN_VAL[idx_s]),
    .credit (credit_s)
  );

  assign bus.coinValid    = valid_r;
  assign bus.coinReject   = reject_r;
  assign bus.coinDetected = det_r;
  assign bus.coinType     = type_r;
  assign bus.credit       = credit_s;
  assign bus.busy         = busy_r;
endmodule

// File: tb/tb_coin_classifier.sv
// Directed self-checking bench for coin_classifier (default parameters).
module tb_coin_classifier;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  coin_classifier_if #(.NUM_TYPES(4), .CREDIT_W(12)) bus();

  coin_classifier dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic r,
                           input logic [3:0] d, input int t, input int c, input logic b);
    chk({tag, ".valid"},    32'(bus.coinValid),    32'(v));
    chk({tag, ".reject"},   32'(bus.coinReject),   32'(r));
    chk({tag, ".detected"}, 32'(bus.coinDetected), 32'(d));
    chk({tag, ".type"},     32'(bus.coinType),     32'(t));
    chk({tag, ".credit"},   32'(bus.credit),       32'(c));
    chk({tag, ".busy"},     32'(bus.busy),         32'(b));
  endtask

  // High for w samples, then one low sample (optionally with clear) and check.
  task automatic pulse(input int w, input logic clr, input logic v, input logic r,
                       input logic [3:0] d, input int t, input int c, input string tag);
    for (int i = 0; i < w; i++) begin
      bus.coinSensor = 1'b1;
      tick();
    end
    chk({tag, ".busy_hi"}, 32'(bus.busy), 32'(1));
    bus.coinSensor  = 1'b0;
    bus.creditClear = clr;
    tick();
    bus.creditClear = 1'b0;
    check_out(tag, v, r, d, t, c, 1'b0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.coinSensor  = 1'b0;
    bus.creditClear = 1'b0;
    tick(); tick(); tick();
    check_out("reset", 1'b0, 1'b0, 4'b0000, 0, 0, 1'b0);
    reset = 1'b0;
    tick();

    pulse(3, 1'b0, 1'b1, 1'b0, 4'b0001, 0, 10, "w3");
    tick();
    check_out("w3_after", 1'b0, 1'b0, 4'b0001, 0, 10, 1'b0);

    pulse(1, 1'b0, 1'b0, 1'b1, 4'b0000, 0, 10, "w1");

    // Back-to-back with a single low sample between coins.
    pulse(7,  1'b0, 1'b1, 1'b0, 4'b0010, 1, 15,  "w7");
    pulse(11, 1'b0, 1'b1, 1'b0, 4'b0100, 2, 40,  "w11");
    pulse(15, 1'b0, 1'b1, 1'b0, 4'b1000, 3, 140, "w15");
    tick();
    check_out("w15_after", 1'b0, 1'b0, 4'b1000, 3, 140, 1'b0);

    pulse(300, 1'b0, 1'b0, 1'b1, 4'b0000, 3, 140, "oversize");
    tick();
    check_out("oversize_after", 1'b0, 1'b0, 4'b0000, 3, 140, 1'b0);

    bus.creditClear = 1'b1;
    tick();
    bus.creditClear = 1'b0;
    check_out("clear", 1'b0, 1'b0, 4'b0000, 3, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      pulse(15, 1'b0, 1'b1, 1'b0, 4'b1000, 3, 100 * (k + 1), "fill100");
    end
    pulse(11, 1'b0, 1'b1, 1'b0, 4'b0100, 2, 4025, "fill25a");
    pulse(11, 1'b0, 1'b1, 1'b0, 4'b0100, 2, 4050, "fill25b");
    pulse(11, 1'b0, 1'b1, 1'b0, 4'b0100, 2, 4075, "fill25c");
    pulse(3,  1'b0, 1'b1, 1'b0, 4'b0001, 0, 4085, "fill10");
    pulse(7,  1'b0, 1'b1, 1'b0, 4'b0010, 1, 4090, "fill5");
    pulse(15, 1'b0, 1'b1, 1'b0, 4'b1000, 3, 4095, "sat100");
    pulse(3,  1'b0, 1'b1, 1'b0, 4'b0001, 0, 4095, "sat10");

    pulse(11, 1'b1, 1'b1, 1'b0, 4'b0100, 2, 25, "clear_add");

    // Reset in the middle of a pulse, sensor kept high afterwards.
    bus.coinSensor = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    check_out("midreset", 1'b0, 1'b0, 4'b0000, 0, 0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_out("held_high", 1'b0, 1'b0, 4'b0000, 0, 0, 1'b0);
    bus.coinSensor = 1'b0;
    tick();
    check_out("held_fall", 1'b0, 1'b0, 4'b0000, 0, 0, 1'b0);
    tick();
    check_out("held_idle", 1'b0, 1'b0, 4'b0000, 0, 0, 1'b0);

    pulse(3, 1'b0, 1'b1, 1'b0, 4'b0001, 0, 10, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
